// File: rtl/fpu_multiplier_if.sv
// Operand/result channel between an FPU operation controller (master) and the
// multiplier (slave).
//
// Handshake: an input transfer happens on a posedge with multiplier_input_STB=1
// and multiplier_BUSY=0. An output transfer happens on a posedge with
// multiplier_output_STB=1 and output_module_BUSY=0. The slave holds
// output_product and multiplier_output_STB stable until that output edge.
interface fpu_multiplier_if;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        multiplier_input_STB;
    logic        multiplier_BUSY;
    logic [31:0] output_product;
    logic        multiplier_output_STB;
    logic        output_module_BUSY;

    modport master (
        output input_a,
        output input_b,
        output multiplier_input_STB,
        input  multiplier_BUSY,
        input  output_product,
        input  multiplier_output_STB,
        output output_module_BUSY
    );

    modport slave (
        input  input_a,
        input  input_b,
        input  multiplier_input_STB,
        output multiplier_BUSY,
        output output_product,
        output multiplier_output_STB,
        input  output_module_BUSY
    );
endinterface

// File: rtl/fpu_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier: flush-to-zero on denormals,
// round-to-nearest-even, one canonical quiet NaN for every NaN result.
module fpu_multiplier #(
    parameter logic [31:0] NAN_CANON = 32'h7FC00000,
    parameter int          EXP_BIAS  = 127
) (
    input  logic              clk,
    input  logic              rst,
    fpu_multiplier_if.slave   mul_if,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        GET_INPUTS,
        UNPACK,
        SPECIAL,
        MULTIPLY,
        NORMALISE,
        ROUND,
        PACK,
        PUT_OUTPUT
    } state_t;

    state_t             state_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               sign_q;
    logic [7:0]         ea_q;
    logic [7:0]         eb_q;
    logic [23:0]        ma_q;
    logic [23:0]        mb_q;
    logic [47:0]        prod_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mant_q;
    logic               guard_q;
    logic               round_q;
    logic               sticky_q;
    logic [31:0]        product_q;
    logic               stb_q;
    logic               busy_q;

    logic               a_nan_d;
    logic               b_nan_d;
    logic               a_inf_d;
    logic               b_inf_d;
    logic               a_zero_d;
    logic               b_zero_d;
    logic signed [9:0]  exp_sum_d;
    logic               round_up_d;
    logic [24:0]        mant_inc_d;

    // Exponent 255 keeps its hidden bit, so the NaN test only needs the fraction.
    assign a_nan_d  = (ea_q == 8'hFF) && (ma_q[22:0] != 23'd0);
    assign b_nan_d  = (eb_q == 8'hFF) && (mb_q[22:0] != 23'd0);
    assign a_inf_d  = (ea_q == 8'hFF) && (ma_q[22:0] == 23'd0);
    assign b_inf_d  = (eb_q == 8'hFF) && (mb_q[22:0] == 23'd0);
    assign a_zero_d = (ea_q == 8'h00);
    assign b_zero_d = (eb_q == 8'h00);

    assign exp_sum_d  = signed'({2'b00, ea_q} + {2'b00, eb_q} - 10'(EXP_BIAS));
    assign round_up_d = guard_q & (round_q | sticky_q | mant_q[0]);
    assign mant_inc_d = {1'b0, mant_q} + {24'd0, round_up_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GET_INPUTS;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sign_q    <= 1'b0;
            ea_q      <= 8'd0;
            eb_q      <= 8'd0;
            ma_q      <= 24'd0;
            mb_q      <= 24'd0;
            prod_q    <= 48'd0;
            exp_q     <= 10'sd0;
            mant_q    <= 24'd0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            product_q <= 32'd0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                GET_INPUTS: begin
                    if (mul_if.multiplier_input_STB) begin
                        a_q     <= mul_if.input_a;
                        b_q     <= mul_if.input_b;
                        busy_q  <= 1'b1;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q  <= a_q[31] ^ b_q[31];
                    ea_q    <= a_q[30:23];
                    eb_q    <= b_q[30:23];
                    ma_q    <= (a_q[30:23] != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
                    mb_q    <= (b_q[30:23] != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
                    state_q <= SPECIAL;
                end
                SPECIAL: begin
                    if (a_nan_d || b_nan_d || (a_inf_d && b_zero_d) || (b_inf_d && a_zero_d)) begin
                        product_q <= NAN_CANON;
                        stb_q     <= 1'b1;
                        state_q   <= PUT_OUTPUT;
                    end else if (a_inf_d || b_inf_d) begin
                        product_q <= {sign_q, 8'hFF, 23'd0};
                        stb_q     <= 1'b1;
                        state_q   <= PUT_OUTPUT;
                    end else if (a_zero_d || b_zero_d) begin
                        product_q <= {sign_q, 31'd0};
                        stb_q     <= 1'b1;
                        state_q   <= PUT_OUTPUT;
                    end else begin
                        state_q <= MULTIPLY;
                    end
                end
                MULTIPLY: begin
                    prod_q  <= {24'd0, ma_q} * {24'd0, mb_q};
                    exp_q   <= exp_sum_d;
                    state_q <= NORMALISE;
                end
                NORMALISE: begin
                    // Product of two [1,2) mantissas lies in [1,4); bit 47 means >= 2.
                    if (prod_q[47]) begin
                        mant_q   <= prod_q[47:24];
                        guard_q  <= prod_q[23];
                        round_q  <= prod_q[22];
                        sticky_q <= |prod_q[21:0];
                        exp_q    <= exp_q + 10'sd1;
                    end else begin
                        mant_q   <= prod_q[46:23];
                        guard_q  <= prod_q[22];
                        round_q  <= prod_q[21];
                        sticky_q <= |prod_q[20:0];
                    end
                    state_q <= ROUND;
                end
                ROUND: begin
                    if (mant_inc_d[24]) begin
                        mant_q <= mant_inc_d[24:1];
                        exp_q  <= exp_q + 10'sd1;
                    end else begin
                        mant_q <= mant_inc_d[23:0];
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    if (exp_q >= 10'sd255) begin
                        product_q <= {sign_q, 8'hFF, 23'd0};
                    end else if (exp_q <= 10'sd0) begin
                        product_q <= {sign_q, 31'd0};
                    end else begin
                        product_q <= {sign_q, exp_q[7:0], mant_q[22:0]};
                    end
                    stb_q   <= 1'b1;
                    state_q <= PUT_OUTPUT;
                end
                PUT_OUTPUT: begin
                    if (!mul_if.output_module_BUSY) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= GET_INPUTS;
                    end
                end
                default: begin
                    state_q <= GET_INPUTS;
                end
            endcase
        end
    end

    assign mul_if.multiplier_BUSY       = busy_q;
    assign mul_if.output_product        = product_q;
    assign mul_if.multiplier_output_STB = stb_q;
    assign state_o                      = state_q;

endmodule

// File: tb/tb_fpu_multiplier.sv
// Self-checking bench for fpu_multiplier: directed corner cases, backpressure,
// mid-operation reset, then randomized operands against an arithmetic model.
module tb_fpu_multiplier;

    logic       clk;
    logic       rst;
    logic [2:0] state_o;

    fpu_multiplier_if mif ();

    fpu_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .mul_if  (mif.slave),
        .state_o (state_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, k;
        bit s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned ma, mb, p, q, rem, half;
        logic [31:0] r;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma = 64'd8388608 + 64'(a[22:0]);
        mb = 64'd8388608 + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            k = 24;
            e = e + 1;
        end else begin
            k = 23;
        end
        q    = p >> k;
        rem  = p - (q << k);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        r = {s, 8'(e), q[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int sel;
        logic [31:0] v;
        sel = $urandom_range(0, 19);
        v   = $urandom;
        if (sel == 0)      v[30:23] = 8'hFF;
        else if (sel == 1) v[30:23] = 8'h00;
        else if (sel == 2) v[30:0]  = 31'd0;
        else if (sel < 6)  v = v;
        else               v[30:23] = 8'($urandom_range(60, 190));
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (mif.multiplier_BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_busy", 32'(mif.multiplier_BUSY), 32'd0);
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] expv;
        int lat, exp_lat;
        exp_q.push_back(ref_mul(a, b));
        exp_lat = is_special(a, b) ? 2 : 6;
        wait_idle();
        mif.output_module_BUSY   = (hold > 0);
        mif.input_a              = a;
        mif.input_b              = b;
        mif.multiplier_input_STB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.multiplier_input_STB = 1'b0;
        mif.input_a              = $urandom;
        mif.input_b              = $urandom;
        check_eq("busy_after_accept", 32'(mif.multiplier_BUSY), 32'd1);
        lat = 0;
        while (!mif.multiplier_output_STB && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        expv = exp_q.pop_front();
        check_eq("product", mif.output_product, expv);
        check_eq("busy_in_put", 32'(mif.multiplier_BUSY), 32'd1);
        for (int i = 0; i < hold; i++) begin
            mif.input_a              = $urandom;
            mif.input_b              = $urandom;
            mif.multiplier_input_STB = 1'b1;
            @(negedge clk);
            check_eq("hold_stb", 32'(mif.multiplier_output_STB), 32'd1);
            check_eq("hold_product", mif.output_product, expv);
            check_eq("hold_busy", 32'(mif.multiplier_BUSY), 32'd1);
        end
        // An input strobe on the output edge itself must not be taken.
        mif.output_module_BUSY = 1'b0;
        @(negedge clk);
        mif.multiplier_input_STB = 1'b0;
        check_eq("stb_after_xfer", 32'(mif.multiplier_output_STB), 32'd0);
        check_eq("busy_after_xfer", 32'(mif.multiplier_BUSY), 32'd0);
        check_eq("product_held", mif.output_product, expv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst                      = 1'b1;
        mif.input_a              = 32'd0;
        mif.input_b              = 32'd0;
        mif.multiplier_input_STB = 1'b0;
        mif.output_module_BUSY   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_stb", 32'(mif.multiplier_output_STB), 32'd0);
        check_eq("reset_busy", 32'(mif.multiplier_BUSY), 32'd0);
        check_eq("reset_product", mif.output_product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_op(32'h3FC00000, 32'h40000000, 0);
        send_op(32'h3F800800, 32'h3F800800, 0);
        send_op(32'h3F800001, 32'h3F800001, 0);
        send_op(32'h7F800000, 32'h00000000, 0);
        send_op(32'hC0000000, 32'h00000000, 0);
        send_op(32'h7FC00001, 32'h3F800000, 0);
        send_op(32'h7F000000, 32'h40000000, 0);
        send_op(32'h0D800000, 32'h0D800000, 0);
        send_op(32'h00400000, 32'h3F800000, 0);
        send_op(32'hFF800000, 32'h40000000, 0);
        send_op(32'h3FFFFFFF, 32'h3FFFFFFF, 0);
        send_op(32'h40400000, 32'hC0A00000, 5);
        send_op(32'h3F800000, 32'h3F800000, 0);

        // Asynchronous reset while the operation sits in MULTIPLY.
        wait_idle();
        mif.input_a              = 32'h3FC00000;
        mif.input_b              = 32'h40000000;
        mif.multiplier_input_STB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.multiplier_input_STB = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_stb", 32'(mif.multiplier_output_STB), 32'd0);
        check_eq("async_rst_busy", 32'(mif.multiplier_BUSY), 32'd0);
        check_eq("async_rst_product", mif.output_product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_op(32'h40000000, 32'h40000000, 0);

        for (int i = 0; i < 200; i++) begin
            send_op(rand_op(), rand_op(), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
